// File: rtl/fma_rr_scheduler.sv
// fma_rr_scheduler: round-robin front end sharing one pipelined FMA PE.
// Optional sticky flags: define FMA_SCHED_STICKY_EN.
module fma_rr_scheduler #(
  parameter int WORDWIDTH = 32,
  parameter int NREQ      = 4,
  parameter int FMA_LAT   = 3,
  parameter int IDW       = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WORDWIDTH-1:0] req_a,
  input  logic [NREQ*WORDWIDTH-1:0] req_b,
  input  logic [NREQ*WORDWIDTH-1:0] req_c,
  input  logic [NREQ*3-1:0]         req_rnd,
  output logic [WORDWIDTH-1:0]      fma_op_a,
  output logic [WORDWIDTH-1:0]      fma_op_b,
  output logic [WORDWIDTH-1:0]      fma_op_c,
  output logic [2:0]                fma_rnd_mode,
  output logic                      fma_gate,
  input  logic [WORDWIDTH-1:0]      fma_result,
  input  logic                      fma_ovf_n,
  input  logic                      fma_unf_n,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [WORDWIDTH-1:0]      rsp_data,
  output logic                      rsp_ovf,
  output logic                      rsp_unf,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic                      busy,
  output logic [NREQ-1:0]           sticky_ovf,
  output logic [NREQ-1:0]           sticky_unf,
  input  logic                      sticky_clr
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_IDLE  = 2'd2
  } state_t;

  state_t               state;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       ptr_nxt;
  logic [NREQ-1:0]      grant;
  logic [IDW-1:0]       grant_id;
  logic                 found;
  int                   scan_i;
  logic [IDW-1:0]       scan_id;
  logic                 xfer;

  logic [WORDWIDTH-1:0] sel_a;
  logic [WORDWIDTH-1:0] sel_b;
  logic [WORDWIDTH-1:0] sel_c;
  logic [2:0]           sel_rnd;

  logic [FMA_LAT:0]     tag_v;
  logic [IDW-1:0]       tag_id [FMA_LAT+1];
  logic                 tail_v;
  logic [IDW-1:0]       tail_id;
  logic [NREQ-1:0]      tail_oh;

  // Grant: first valid requester at or above the pointer, wrapping.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    scan_i   = 0;
    scan_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_i = int'(ptr) + k;
      if (scan_i >= NREQ)
        scan_i = scan_i - NREQ;
      scan_id = IDW'(scan_i);
      if (state == S_RUN && !found && req_valid[scan_id]) begin
        found           = 1'b1;
        grant[scan_id]  = 1'b1;
        grant_id        = scan_id;
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = found;

  // Operand mux: AND-OR over the one-hot grant.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_c   = '0;
    sel_rnd = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_a   = sel_a |
        (req_a[i*WORDWIDTH +: WORDWIDTH] & {WORDWIDTH{grant[i]}});
      sel_b   = sel_b |
        (req_b[i*WORDWIDTH +: WORDWIDTH] & {WORDWIDTH{grant[i]}});
      sel_c   = sel_c |
        (req_c[i*WORDWIDTH +: WORDWIDTH] & {WORDWIDTH{grant[i]}});
      sel_rnd = sel_rnd | (req_rnd[i*3 +: 3] & {3{grant[i]}});
    end
  end

  assign ptr_nxt = (grant_id == IDW'(NREQ-1)) ?
                   '0 : grant_id + 1'b1;

  // Pointer moves past the winner only on a transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ptr <= '0;
    else if (xfer)
      ptr <= ptr_nxt;
  end

  // Issue register: operands hold when nothing is transferred.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fma_op_a     <= '0;
      fma_op_b     <= '0;
      fma_op_c     <= '0;
      fma_rnd_mode <= '0;
      fma_gate     <= 1'b0;
    end else begin
      fma_gate <= xfer;
      if (xfer) begin
        fma_op_a     <= sel_a;
        fma_op_b     <= sel_b;
        fma_op_c     <= sel_c;
        fma_rnd_mode <= sel_rnd;
      end
    end
  end

  // Tag pipe tracks owner of each op alongside the PE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_v <= '0;
      for (int j = 0; j <= FMA_LAT; j++)
        tag_id[j] <= '0;
    end else begin
      tag_v[0]  <= xfer;
      tag_id[0] <= grant_id;
      for (int j = 1; j <= FMA_LAT; j++) begin
        tag_v[j]  <= tag_v[j-1];
        tag_id[j] <= tag_id[j-1];
      end
    end
  end

  assign tail_v  = tag_v[FMA_LAT];
  assign tail_id = tag_id[FMA_LAT];

  // Decode tail owner into a one-hot strobe.
  always_comb begin
    tail_oh = '0;
    for (int i = 0; i < NREQ; i++)
      if (tail_v && tail_id == IDW'(i))
        tail_oh[i] = 1'b1;
  end

  // Response register: capture PE result under the tail tag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_ovf   <= 1'b0;
      rsp_unf   <= 1'b0;
    end else begin
      rsp_valid <= tail_oh;
      rsp_ovf   <= tail_v & ~fma_ovf_n;
      rsp_unf   <= tail_v & ~fma_unf_n;
      if (tail_v)
        rsp_data <= fma_result;
    end
  end

  assign busy = fma_gate | (|tag_v);

  // Drain control: stop granting, wait for empty pipe, hold idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_RUN;
      drain_done <= 1'b0;
    end else begin
      unique case (state)
        S_RUN: begin
          drain_done <= 1'b0;
          if (drain_req)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!busy) begin
            state      <= S_IDLE;
            drain_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (!drain_req) begin
            state      <= S_RUN;
            drain_done <= 1'b0;
          end
        end
        default: begin
          state      <= S_RUN;
          drain_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef FMA_SCHED_STICKY_EN
  // Sticky flags: a same-cycle set beats the clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky_ovf <= '0;
      sticky_unf <= '0;
    end else begin
      sticky_ovf <= (sticky_clr ? '0 : sticky_ovf) |
                    (tail_oh & {NREQ{~fma_ovf_n}});
      sticky_unf <= (sticky_clr ? '0 : sticky_unf) |
                    (tail_oh & {NREQ{~fma_unf_n}});
    end
  end
`else
  logic sticky_clr_unused;
  assign sticky_clr_unused = sticky_clr;
  assign sticky_ovf = '0;
  assign sticky_unf = '0;
`endif

endmodule

// File: tb/tb_fma_rr_scheduler.sv
// tb_fma_rr_scheduler: directed bench with cycle model of fma_rr_scheduler.
// Stand-in PE returns exact values for the directed vectors.
module tb_fma_rr_scheduler;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int L   = 3;
  localparam int IDW = 2;
`ifdef FMA_SCHED_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic [N*3-1:0] req_rnd = '0;
  logic [W-1:0]   fma_op_a, fma_op_b, fma_op_c;
  logic [2:0]     fma_rnd_mode;
  logic           fma_gate;
  logic [W-1:0]   fma_result;
  logic           fma_ovf_n, fma_unf_n;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_ovf, rsp_unf;
  logic           drain_req = 1'b0;
  logic           drain_done, busy;
  logic [N-1:0]   sticky_ovf, sticky_unf;
  logic           sticky_clr = 1'b0;

  fma_rr_scheduler #(
    .WORDWIDTH(W), .NREQ(N), .FMA_LAT(L), .IDW(IDW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .req_rnd(req_rnd),
    .fma_op_a(fma_op_a), .fma_op_b(fma_op_b),
    .fma_op_c(fma_op_c), .fma_rnd_mode(fma_rnd_mode),
    .fma_gate(fma_gate), .fma_result(fma_result),
    .fma_ovf_n(fma_ovf_n), .fma_unf_n(fma_unf_n),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf),
    .drain_req(drain_req), .drain_done(drain_done),
    .busy(busy),
    .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
    .sticky_clr(sticky_clr)
  );

  // {ovf_n, unf_n, result}
  function automatic logic [33:0] pe_f(
    input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    if (a == 32'h40000000 && b == 32'h40400000 && c == 32'h3F800000)
      return {2'b11, 32'h40E00000};
    if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF)
      return {2'b01, 32'h7F800000};
    if (a == 32'h00800000 && b == 32'h00800000)
      return {2'b10, 32'h00000000};
    return {2'b11, (a + {b[15:0], b[31:16]}) ^ c};
  endfunction

  logic [33:0] pe_pipe [L];
  always @(posedge clk) begin
    pe_pipe[0] <= fma_gate ? pe_f(fma_op_a, fma_op_b, fma_op_c)
                           : {2'b00, 32'hDEADBEEF};
    for (int j = 1; j < L; j++)
      pe_pipe[j] <= pe_pipe[j-1];
  end
  assign fma_result = pe_pipe[L-1][31:0];
  assign fma_ovf_n  = pe_pipe[L-1][33];
  assign fma_unf_n  = pe_pipe[L-1][32];

  int tests = 0;
  int errs  = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          due;
    int          id;
    logic [31:0] a, b, c, d;
    logic [2:0]  rnd;
    logic        ovf, unf;
  } ent_t;

  ent_t q[$];
  int   mptr   = 0;
  int   mstate = 0;
  logic [N-1:0] m_so = '0, m_su = '0;

  int   gnt_log[$], gnt_cyc[$], rsp_log[$], rsp_cyc[$];
  logic [31:0] dat_log[$];
  int   gate_cnt = 0;
  int   last_rsp_cyc = 0;
  int   done_cyc = 0;
  bit   done_seen = 0;

  // Model and compare: outputs are checked mid-cycle every cycle.
  always @(negedge clk) begin : model
    logic [N-1:0] er, ev;
    int   gi;
    logic eg, eb, eo, eu;
    ent_t ge, re, ne;
    if (!rstn) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_flags", {rsp_ovf, rsp_unf}, 0);
      chk("rst_gate", fma_gate, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", drain_done, 0);
      chk("rst_sticky", {sticky_ovf, sticky_unf}, 0);
      q.delete();
      mptr = 0; mstate = 0; m_so = '0; m_su = '0;
    end else begin
      er = '0; gi = -1;
      if (mstate == 0)
        for (int k = 0; k < N; k++)
          if (gi < 0 && req_valid[(mptr + k) % N]) begin
            gi = (mptr + k) % N;
            er[gi] = 1'b1;
          end
      chk("req_ready", req_ready, er);
      eg = 0; eb = 0; ev = '0;
      ge = '{default: 0}; re = '{default: 0};
      foreach (q[i]) begin
        if (q[i].due == cyc + 1 + L) begin eg = 1; ge = q[i]; end
        if (cyc >= q[i].due - 1 - L && cyc <= q[i].due - 1) eb = 1;
        if (q[i].due == cyc) begin ev[q[i].id] = 1'b1; re = q[i]; end
      end
      chk("fma_gate", fma_gate, eg);
      if (eg)
        chk("fma_ops", {fma_op_a, fma_op_b, fma_op_c, fma_rnd_mode},
            {ge.a, ge.b, ge.c, ge.rnd});
      chk("busy", busy, eb);
      chk("drain_done", drain_done, mstate == 2);
      chk("rsp_valid", rsp_valid, ev);
      eo = (|ev) & re.ovf;
      eu = (|ev) & re.unf;
      if (|ev) chk("rsp_data", rsp_data, re.d);
      chk("rsp_flags", {rsp_ovf, rsp_unf}, {eo, eu});
      chk("sticky", {sticky_ovf, sticky_unf}, {m_so, m_su});
      for (int k = 0; k < N; k++) begin
        if (req_ready[k] && req_valid[k]) begin
          gnt_log.push_back(k); gnt_cyc.push_back(cyc);
        end
        if (rsp_valid[k]) begin
          rsp_log.push_back(k); rsp_cyc.push_back(cyc);
          dat_log.push_back(rsp_data); last_rsp_cyc = cyc;
        end
      end
      if (fma_gate) gate_cnt++;
      if (drain_done && !done_seen) begin
        done_seen = 1; done_cyc = cyc;
      end
      if (gi >= 0) begin
        ne.due = cyc + 2 + L; ne.id = gi;
        ne.a = req_a[gi*W +: W]; ne.b = req_b[gi*W +: W];
        ne.c = req_c[gi*W +: W]; ne.rnd = req_rnd[gi*3 +: 3];
        {ne.ovf, ne.unf, ne.d} = pe_f(ne.a, ne.b, ne.c);
        ne.ovf = ~ne.ovf; ne.unf = ~ne.unf;
        q.push_back(ne);
        mptr = (gi + 1) % N;
      end
      if (STK) begin
        if (sticky_clr) begin m_so = '0; m_su = '0; end
        foreach (q[i])
          if (q[i].due == cyc + 1) begin
            if (q[i].ovf) m_so[q[i].id] = 1'b1;
            if (q[i].unf) m_su[q[i].id] = 1'b1;
          end
      end
      case (mstate)
        0: if (drain_req) mstate = 1;
        1: if (!eb) mstate = 2;
        default: if (!drain_req) mstate = 0;
      endcase
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c,
                        input logic [2:0] r);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_c[i*W +: W] = c;
    req_rnd[i*3 +: 3] = r;
  endtask

  task automatic clr_logs();
    gnt_log.delete(); gnt_cyc.delete();
    rsp_log.delete(); rsp_cyc.delete(); dat_log.delete();
    gate_cnt = 0; done_seen = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ef[8];
    int ep[3];
    int n;
    ef = '{0, 1, 2, 3, 0, 1, 2, 3};
    ep = '{2, 3, 1};
    #1 rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();

    // single op
    clr_logs();
    set_op(0, 32'h40000000, 32'h40400000, 32'h3F800000, 3'd0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (L + 4) tick();
    chk("single_rsp_count", rsp_log.size(), 1);
    chk("single_rsp_id", rsp_log[0], 0);
    chk("single_rsp_data", dat_log[0], 32'h40E00000);
    chk("single_latency", rsp_cyc[0] - gnt_cyc[0], L + 2);
    chk("single_gate_cycles", gate_cnt, 1);

    // async reset mid-stream
    set_op(1, 32'h11, 32'h22, 32'h33, 3'd1);
    set_op(2, 32'h44, 32'h55, 32'h66, 3'd2);
    req_valid = 4'b0110;
    tick(); tick();
    rstn = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_now_busy", busy, 0);
    chk("rst_now_gate", fma_gate, 0);
    chk("rst_now_ops", fma_op_a, 0);
    tick(); tick();
    rstn = 1'b1;
    n = rsp_log.size();
    repeat (L + 4) tick();
    chk("rst_no_stray_rsp", rsp_log.size(), n);

    // fairness
    clr_logs();
    for (int i = 0; i < N; i++)
      set_op(i, 32'h100 + i, 32'h200 + i, 32'h300 + i, 3'(i));
    req_valid = 4'b1111;
    repeat (8) tick();
    req_valid = '0;
    repeat (L + 4) tick();
    chk("fair_gnt_count", gnt_log.size(), 8);
    chk("fair_rsp_count", rsp_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("fair_gnt_order", gnt_log[i], ef[i]);
      chk("fair_rsp_order", rsp_log[i], ef[i]);
    end

    // pointer
    clr_logs();
    req_valid = 4'b0100; tick();
    req_valid = 4'b1010; tick();
    req_valid = 4'b0010; tick();
    req_valid = '0;
    repeat (L + 4) tick();
    chk("ptr_gnt_count", gnt_log.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("ptr_gnt_order", gnt_log[i], ep[i]);

    // drain
    clr_logs();
    req_valid = 4'b1111;
    tick(); tick();
    drain_req = 1'b1;
    tick();
    chk("drain_ready_low", req_ready, 0);
    for (int i = 0; i < 30 && !done_seen; i++) tick();
    chk("drain_done_seen", done_seen, 1);
    chk("drain_gnt_count", gnt_log.size(), 3);
    chk("drain_rsp_count", rsp_log.size(), 3);
    chk("drain_after_last_rsp", done_cyc - last_rsp_cyc, 1);
    tick(); tick();
    chk("drain_done_hold", drain_done, 1);
    gnt_log.delete();
    drain_req = 1'b0;
    tick(); tick();
    req_valid = '0;
    chk("resume_gnt_count", gnt_log.size(), 1);
    chk("resume_gnt_id", gnt_log[0], 1);
    chk("resume_done_low", drain_done, 0);
    repeat (L + 4) tick();

    // sticky overflow, clear in the set cycle, then clear
    set_op(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 3'd1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    repeat (3) tick();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("ovf_rsp_valid", rsp_valid, 4'b0010);
    chk("ovf_rsp_flag", rsp_ovf, 1);
    chk("ovf_sticky_set", sticky_ovf[1], STK);
    repeat (3) tick();
    chk("ovf_sticky_hold", sticky_ovf[1], STK);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("ovf_sticky_clr", sticky_ovf, 0);

    // sticky underflow
    set_op(3, 32'h00800000, 32'h00800000, 32'h0, 3'd0);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    repeat (L + 4) tick();
    chk("unf_sticky_set", sticky_unf[3], STK);

    // mixed burst with drain and clear activity
    for (int t = 0; t < 80; t++) begin
      for (int i = 0; i < N; i++)
        set_op(i, $urandom, $urandom, $urandom,
               3'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) == 0)
        set_op($urandom_range(0, 3), 32'h7F7FFFFF, 32'h7F7FFFFF,
               32'h0, 3'd0);
      req_valid  = 4'($urandom_range(0, 15));
      sticky_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 11) == 0) drain_req = ~drain_req;
      tick();
    end
    req_valid = '0; drain_req = 1'b0; sticky_clr = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
